// File: rtl/fake_netlist_pkg.sv
// rtl/fake_netlist_pkg.sv - shared types and constants for the fake-netlist vector driver
package fake_netlist_pkg;

  localparam int VEC_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_EMIT    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Galois right-shift feedback masks, maximal-length for each supported width
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      3:       lfsr_taps = 16'h0006;
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      16:      lfsr_taps = 16'hB400;
      default: lfsr_taps = 16'h0014;
    endcase
  endfunction

endpackage

// File: rtl/fake_vec_lfsr.sv
// rtl/fake_vec_lfsr.sv - seedable Galois LFSR with load and step controls
module fake_vec_lfsr #(
  parameter int             W    = 5,
  parameter logic [W-1:0]   TAPS = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  // An all-zero seed would lock the register, so it is promoted to 1
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == '0) ? W'(1) : seed;
    end else if (step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/fake_vector_driver.sv
// rtl/fake_vector_driver.sv - drives vectors into a combinational netlist and packs its responses
module fake_vector_driver
  import fake_netlist_pkg::*;
#(
  parameter int IN_W       = 5,
  parameter int RESP_W     = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [IN_W-1:0]   seed,
  input  logic [15:0]       vec_cnt,
  output logic [IN_W-1:0]   dut_in,
  input  logic              dut_out,
  output logic [RESP_W-1:0] resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy,
  output logic              done
);

  localparam int WI_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW   = VEC_CNT_W + 1;
  localparam logic [RW-1:0]   FULL_CNT = RW'(1) << IN_W;
  localparam logic [IN_W-1:0] TAPS     = IN_W'(lfsr_taps(IN_W));

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [IN_W-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [WI_W-1:0]   widx_q, widx_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [RESP_W-1:0] word_q, word_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic              lfsr_load, lfsr_step;
  logic [IN_W-1:0]   lfsr_state;

  fake_vec_lfsr #(
    .W    (IN_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed),
    .state (lfsr_state)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    widx_d    = widx_q;
    settle_d  = settle_q;
    word_d    = word_q;
    dut_in_d  = dut_in_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = mode;
          cnt_d     = '0;
          rem_d     = (vec_cnt == '0) ? FULL_CNT : {1'b0, vec_cnt};
          widx_d    = '0;
          word_d    = '0;
          lfsr_load = 1'b1;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        dut_in_d = mode_q ? lfsr_state : cnt_q;
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SC_W'(SETTLE_CYC - 1)) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Next vector is prepared here so DRIVE only has to register it
        word_d = word_q | (RESP_W'(dut_out) << widx_q);
        rem_d  = rem_q - 1'b1;
        if (mode_q) begin
          lfsr_step = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if ((widx_q == WI_W'(RESP_W - 1)) || (rem_q == RW'(1))) begin
          state_d = ST_EMIT;
        end else begin
          widx_d  = widx_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_EMIT: begin
        if (resp_ready) begin
          word_d  = '0;
          widx_d  = '0;
          state_d = (rem_q == '0) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      widx_q   <= '0;
      settle_q <= '0;
      word_q   <= '0;
      dut_in_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      widx_q   <= widx_d;
      settle_q <= settle_d;
      word_q   <= word_d;
      dut_in_q <= dut_in_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign resp_data  = word_q;
  assign resp_valid = (state_q == ST_EMIT);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_fake_vector_driver.sv
// tb/tb_fake_vector_driver.sv - scoreboard bench for fake_vector_driver with a behavioural netlist
module tb_fake_vector_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  seed = '0;
  logic [15:0] vec_cnt = '0;
  logic [4:0]  dut_in;
  logic        dut_out;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int fails = 0;
  int net_sel = 0;

  logic [7:0] exp_q[$];
  logic [4:0] exp_vecs[$];
  logic [4:0] vec_log[$];

  always #5 clk = ~clk;

  function automatic logic netlist(input int sel, input logic [4:0] v);
    case (sel)
      0:       netlist = 1'b1;
      1:       netlist = v[0];
      default: netlist = (v[0] & v[1]) | (v[2] ^ v[3] ^ v[4]);
    endcase
  endfunction

  assign dut_out = netlist(net_sel, dut_in);

  fake_vector_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .seed       (seed),
    .vec_cnt    (vec_cnt),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // x^5+x^3+1, Galois form shifting right
  function automatic logic [4:0] lfsr_next(input logic [4:0] v);
    return {1'b0, v[4:1]} ^ (v[0] ? 5'b10100 : 5'b00000);
  endfunction

  task automatic build_expected(input logic m, input logic [4:0] sd, input int n);
    logic [4:0] v;
    logic [7:0] w;
    int k;
    v = m ? ((sd == 5'd0) ? 5'd1 : sd) : 5'd0;
    w = '0;
    k = 0;
    exp_vecs.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_vecs.push_back(v);
      w[k] = netlist(net_sel, v);
      k++;
      if (k == 8 || i == n - 1) begin
        exp_q.push_back(w);
        w = '0;
        k = 0;
      end
      v = m ? lfsr_next(v) : v + 5'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input logic m, input logic [4:0] sd, input logic [15:0] vc,
                     input int stall_w, input int stall_l, input bit poke, input string tag);
    int n, nw, busy_cyc, words, stalled, last_acc;
    logic [7:0] held;
    logic [4:0] frozen, last_in;
    bit done_seen;
    n = (vc == 16'd0) ? 32 : int'(vc);
    nw = (n + 7) / 8;
    build_expected(m, sd, n);
    vec_log.delete();
    last_in = dut_in;
    @(negedge clk);
    mode = m;
    seed = sd;
    vec_cnt = vc;
    start = 1'b1;
    resp_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mode = ~m;
    seed = ~sd;
    vec_cnt = 16'hFFFF;
    busy_cyc = 0;
    words = 0;
    stalled = 0;
    last_acc = -10;
    held = '0;
    frozen = '0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      start = 1'b0;
      if (busy) busy_cyc++;
      chk({tag, "_done_valid_excl"}, {31'd0, done & resp_valid}, 32'd0);
      if ((cyc % 3 == 2) && (cyc / 3 < n) && (cyc / 3 < 8))
        chk({tag, "_vec"}, {27'd0, dut_in}, {27'd0, exp_vecs[cyc / 3]});
      if (dut_in !== last_in) begin
        vec_log.push_back(dut_in);
        last_in = dut_in;
      end
      if (poke && cyc == 4) start = 1'b1;
      if (resp_valid) begin
        if (words == stall_w && stalled < stall_l) begin
          if (stalled == 0) begin
            held = resp_data;
            frozen = dut_in;
          end else begin
            chk({tag, "_stall_data"}, {24'd0, resp_data}, {24'd0, held});
            chk({tag, "_stall_dut_in"}, {27'd0, dut_in}, {27'd0, frozen});
          end
          stalled++;
          resp_ready = 1'b0;
        end else begin
          resp_ready = 1'b1;
          if (exp_q.size() > 0) chk({tag, "_word"}, {24'd0, resp_data}, {24'd0, exp_q.pop_front()});
          words++;
          last_acc = cyc;
        end
      end else begin
        resp_ready = 1'b0;
      end
      if (done) begin
        done_seen = 1'b1;
        chk({tag, "_done_timing"}, cyc, last_acc + 1);
      end
      @(negedge clk);
    end
    start = 1'b0;
    resp_ready = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
    chk({tag, "_words"}, words, nw);
    chk({tag, "_busy_cycles"}, busy_cyc, 3 * n + nw + stall_l + 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_idle_after"}, {29'd0, busy, done, resp_valid}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dups, zeros, diffs, cnt;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {16'd0, dut_in, resp_data, resp_valid, busy, done}, 32'd0);
    rst_n = 1'b1;

    // T1: all-ones netlist, full 32-vector sweep
    net_sel = 0;
    run(1'b0, 5'd0, 16'd0, -1, 0, 1'b0, "t1");

    // T2: response follows dut_in[0]
    do_reset();
    net_sel = 1;
    run(1'b0, 5'd0, 16'd3, -1, 0, 1'b0, "t2");

    // T3: LFSR from zero seed walks all nonzero states
    do_reset();
    net_sel = 2;
    run(1'b1, 5'd0, 16'd31, -1, 0, 1'b0, "t3");
    chk("t3_log_len", vec_log.size(), 31);
    if (vec_log.size() > 0) chk("t3_first_vec", {27'd0, vec_log[0]}, 32'd1);
    dups = 0;
    zeros = 0;
    diffs = 0;
    for (int i = 0; i < vec_log.size(); i++) begin
      if (vec_log[i] == 5'd0) zeros++;
      if (i < exp_vecs.size() && vec_log[i] !== exp_vecs[i]) diffs++;
      for (int j = i + 1; j < vec_log.size(); j++)
        if (vec_log[i] == vec_log[j]) dups++;
    end
    chk("t3_distinct", dups, 0);
    chk("t3_nonzero", zeros, 0);
    chk("t3_sequence", diffs, 0);

    // T4: consumer stalls the first word for 10 cycles
    run(1'b1, 5'h0B, 16'd12, 0, 10, 1'b0, "t4");

    // wrap of the binary count beyond 32 vectors
    run(1'b0, 5'd0, 16'd40, 2, 3, 1'b0, "wrap");

    // T5: asynchronous reset while a word is stalled
    @(negedge clk);
    mode = 1'b0;
    vec_cnt = 16'd8;
    start = 1'b1;
    resp_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!resp_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5_reach_emit", {31'd0, resp_valid}, 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", {16'd0, dut_in, resp_data, resp_valid, busy, done}, 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("t5_no_done", cnt, 0);
    rst_n = 1'b1;
    run(1'b0, 5'd0, 16'd5, -1, 0, 1'b0, "t5_after");

    // T6: start re-pulsed mid-run must be ignored
    run(1'b0, 5'd0, 16'd20, -1, 0, 1'b1, "t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
